// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the DRAM request arbiter.
// State encodings are fixed so that debug traces decode the same everywhere.
package dram_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dram_arb_rr_picker.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
// Zero latency; valid is low when no request is pending.
module rr_picker #(
    parameter int NUM_CORES = 4,
    localparam int IDX_W = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [IDX_W-1:0]     winner,
    output logic                 valid
);

    always_comb begin
        int             j;
        logic [IDX_W-1:0] idx;
        valid  = 1'b0;
        winner = '0;
        j      = 0;
        idx    = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            j = int'(last_grant) + i;
            if (j >= NUM_CORES) j = j - NUM_CORES;
            idx = IDX_W'(j);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_CORES requesters.
// Latency: latch to ack 2 cycles, one access per 3 cycles; requests wait until acked.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_CORES-1:0]        i_req_rd,
    input  logic [NUM_CORES-1:0]        i_req_wr,
    input  logic [NUM_CORES*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] i_req_wdata,
    output logic [NUM_CORES-1:0]        o_ack,
    output logic [NUM_CORES*DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic                        o_mem_we,
    output logic [DATA_W-1:0]           o_mem_wdata,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    output logic                        o_busy
);

    localparam int IDX_W = $clog2(NUM_CORES);

    state_t                      state;
    state_t                      state_nxt;
    logic [IDX_W-1:0]            last_grant;
    logic [IDX_W-1:0]            pick_idx;
    logic                        pick_vld;
    logic [IDX_W-1:0]            lat_idx;
    logic                        lat_wr;
    logic [ADDR_W-1:0]           lat_addr;
    logic [DATA_W-1:0]           lat_wdata;
    logic [NUM_CORES*DATA_W-1:0] rdata_q;
    logic [NUM_CORES-1:0]        req_any;

    assign req_any = i_req_rd | i_req_wr;

    rr_picker #(.NUM_CORES(NUM_CORES)) u_picker (
        .req        (req_any),
        .last_grant (last_grant),
        .winner     (pick_idx),
        .valid      (pick_vld)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is forwarded during the ack cycle so it is visible together with the ack.
    always_comb begin
        o_busy   = (state != IDLE);
        o_mem_we = (state == ACCESS) && lat_wr;
        o_ack    = '0;
        o_rdata  = rdata_q;
        if (state == DONE) begin
            o_ack[lat_idx] = 1'b1;
            if (!lat_wr) o_rdata[lat_idx*DATA_W +: DATA_W] = i_mem_rdata;
        end
    end

    // rd+wr together latches as a write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant <= IDX_W'(NUM_CORES - 1);
            lat_idx    <= '0;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        lat_idx   <= pick_idx;
                        lat_wr    <= i_req_wr[pick_idx];
                        lat_addr  <= i_req_addr[pick_idx*ADDR_W +: ADDR_W];
                        lat_wdata <= i_req_wdata[pick_idx*DATA_W +: DATA_W];
                    end
                end
                DONE: begin
                    last_grant <= lat_idx;
                    if (!lat_wr) rdata_q[lat_idx*DATA_W +: DATA_W] <= i_mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr  = lat_addr;
    assign o_mem_wdata = lat_wdata;

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL expose parameter NUM_CORES, default 4, number of core request ports (2..8).
REQ-002 SHALL expose parameter ADDR_W, default 16, memory word address width.
REQ-003 SHALL expose parameter DATA_W, default 8, memory data width.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_req_rd  input  NUM_CORES  per-core read request; held until that core's ack.
REQ-007 i_req_wr  input  NUM_CORES  per-core write request; held until that core's ack.
REQ-008 i_req_addr  input  NUM_CORES*ADDR_W  flattened per-core address; core k at bits [k*ADDR_W +: ADDR_W].
REQ-009 i_req_wdata  input  NUM_CORES*DATA_W  flattened per-core write data.
REQ-010 o_ack  output  NUM_CORES  one-cycle completion pulse per core.
REQ-011 o_rdata  output  NUM_CORES*DATA_W  per-core registered read data, valid from the ack cycle until that core's next read ack.
REQ-012 o_mem_addr  output  ADDR_W  address to the single-port data memory.
REQ-013 o_mem_we  output  1  memory write enable.
REQ-014 o_mem_wdata  output  DATA_W  memory write data.
REQ-015 i_mem_rdata  input  DATA_W  memory read data; valid one cycle after the address is presented.
REQ-016 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE; transitions IDLE->ACCESS when any request is pending, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-018 In IDLE the winner is chosen round-robin: search starts at (last_grant+1) mod NUM_CORES; winner index, op, address and write data are latched.
REQ-019 A core asserting rd and wr together is treated as a write.
REQ-020 In ACCESS: o_mem_addr = latched address; o_mem_we = 1 only for a write; o_mem_wdata = latched data.
REQ-021 In DONE: for a read, i_mem_rdata is captured into the winner's o_rdata slice; o_ack[winner] pulses high for exactly this cycle; last_grant <= winner.
REQ-022 Latency: request first sampled in IDLE at edge N -> ack high in cycle N+2 (DONE); one access per 3 cycles, new arbitration the cycle after DONE.
REQ-023 Requests deasserted after latch do not abort the transaction; the ack is still issued.
REQ-024 Requests arriving while busy wait; no request is ever lost or reordered relative to its own core.
REQ-025 Starvation bound: a continuously asserted request is acked within NUM_CORES transactions.
REQ-026 Outside ACCESS, o_mem_we = 0; o_mem_addr/o_mem_wdata hold the last latched values.
REQ-027 At most one o_ack bit is high in any cycle.

Reset
REQ-028 On i_rst high at a rising edge: state <= IDLE, last_grant <= NUM_CORES-1 (core 0 highest first priority), o_ack <= 0, all o_rdata <= 0, latched addr/data <= 0.
REQ-029 Reset mid-transaction aborts it with no ack; a write whose ACCESS cycle coincided with the reset edge is committed to memory.
REQ-030 While i_rst is high, o_mem_we = 0 and o_busy = 0 from the cycle after the first reset edge.

Structure
REQ-031 Shared package dram_arb_pkg holds state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the ADDR_W/DATA_W defaults.
REQ-032 One sub-module rr_picker: combinational round-robin winner from request vector and last_grant, outputs winner index and valid.

Verification
REQ-033 Single read: core 2 rd addr 16'h0010, memory holds 8'hA5 -> o_mem_addr=16'h0010 in ACCESS, o_ack[2] pulse 2 cycles after latch, o_rdata[2]=8'hA5.
REQ-034 Single write: core 1 wr addr 16'h0100 data 8'h3C -> exactly one o_mem_we cycle with addr 16'h0100 data 8'h3C; readback by core 0 returns 8'h3C.
REQ-035 All four cores request simultaneously from reset -> acks in order 0,1,2,3, each 3 cycles apart, no two acks in one cycle.
REQ-036 Cores 0 and 3 held continuously -> grants alternate 0,3,0,3; neither waits more than 2 transactions.
REQ-037 Reset asserted during ACCESS of a read by core 1 -> no o_ack[1], state IDLE, o_busy 0, o_rdata all zero.
REQ-038 Core 2 asserts rd and wr together with data 8'h77 -> treated as write, o_mem_we high one cycle, o_rdata[2] unchanged.
